// File: rtl/piso_tx_nbit.sv
// piso_tx_nbit: N-bit parallel-in, serial-out transmitter with start/ready handshake.
// Define PIPO_PARITY_EN to append one even-parity bit after the data bits.
module piso_tx_nbit #(
    parameter int N         = 8,
    parameter bit MSB_FIRST = 1'b1
) (
    input  logic         clock,
    input  logic         R_n,
    input  logic [N-1:0] D,
    input  logic         start,
    input  logic         E,
    output logic         ready,
    output logic         Q,
    output logic         valid,
    output logic         done
);

    localparam int CW = $clog2(N + 1);
    localparam logic [CW-1:0] LAST = CW'(N - 1);

`ifdef PIPO_PARITY_EN
    typedef enum logic [1:0] {S_IDLE, S_SHIFT, S_PARITY} state_t;
`else
    typedef enum logic [1:0] {S_IDLE, S_SHIFT} state_t;
`endif

    state_t         r_state, w_state_nx;
    logic [N-1:0]   r_shift, w_shift_nx;
    logic [CW-1:0]  r_cnt,   w_cnt_nx;
    logic           r_q,     w_q_nx;
    logic           r_valid, w_valid_nx;
    logic           r_ready, w_ready_nx;
    logic           r_done,  w_done_nx;
`ifdef PIPO_PARITY_EN
    logic           r_par,   w_par_nx;
`endif

    logic [N-1:0]   w_shifted;
    logic           w_head_d;
    logic           w_head_sh;

    // Shift toward the output end so the next bit is always at the head.
    assign w_shifted = MSB_FIRST ? {r_shift[N-2:0], 1'b0}
                                 : {1'b0, r_shift[N-1:1]};
    assign w_head_d  = MSB_FIRST ? D[N-1] : D[0];
    assign w_head_sh = MSB_FIRST ? w_shifted[N-1] : w_shifted[0];

    always_comb begin
        w_state_nx = r_state;
        w_shift_nx = r_shift;
        w_cnt_nx   = r_cnt;
        w_q_nx     = r_q;
        w_valid_nx = r_valid;
        w_ready_nx = r_ready;
        w_done_nx  = 1'b0;
`ifdef PIPO_PARITY_EN
        w_par_nx   = r_par;
`endif
        case (r_state)
            S_IDLE: begin
                if (start) begin
                    w_state_nx = S_SHIFT;
                    w_shift_nx = D;
                    w_cnt_nx   = '0;
                    w_q_nx     = w_head_d;
                    w_valid_nx = 1'b1;
                    w_ready_nx = 1'b0;
`ifdef PIPO_PARITY_EN
                    w_par_nx   = ^D;
`endif
                end
            end
            S_SHIFT: begin
                if (E) begin
                    w_shift_nx = w_shifted;
                    w_cnt_nx   = r_cnt + CW'(1);
                    w_q_nx     = w_head_sh;
                    if (r_cnt == LAST) begin
`ifdef PIPO_PARITY_EN
                        w_state_nx = S_PARITY;
                        w_q_nx     = r_par;
`else
                        w_state_nx = S_IDLE;
                        w_q_nx     = 1'b0;
                        w_valid_nx = 1'b0;
                        w_ready_nx = 1'b1;
                        w_done_nx  = 1'b1;
`endif
                    end
                end
            end
`ifdef PIPO_PARITY_EN
            S_PARITY: begin
                if (E) begin
                    w_state_nx = S_IDLE;
                    w_q_nx     = 1'b0;
                    w_valid_nx = 1'b0;
                    w_ready_nx = 1'b1;
                    w_done_nx  = 1'b1;
                end
            end
`endif
            default: begin
                w_state_nx = S_IDLE;
                w_q_nx     = 1'b0;
                w_valid_nx = 1'b0;
                w_ready_nx = 1'b1;
            end
        endcase
    end

    always_ff @(posedge clock or negedge R_n) begin
        if (!R_n) begin
            r_state <= S_IDLE;
            r_shift <= '0;
            r_cnt   <= '0;
            r_q     <= 1'b0;
            r_valid <= 1'b0;
            r_ready <= 1'b1;
            r_done  <= 1'b0;
`ifdef PIPO_PARITY_EN
            r_par   <= 1'b0;
`endif
        end else begin
            r_state <= w_state_nx;
            r_shift <= w_shift_nx;
            r_cnt   <= w_cnt_nx;
            r_q     <= w_q_nx;
            r_valid <= w_valid_nx;
            r_ready <= w_ready_nx;
            r_done  <= w_done_nx;
`ifdef PIPO_PARITY_EN
            r_par   <= w_par_nx;
`endif
        end
    end

    assign ready = r_ready;
    assign Q     = r_q;
    assign valid = r_valid;
    assign done  = r_done;

endmodule

// File: tb/tb_piso_tx_nbit.sv
// tb_piso_tx_nbit: directed bench for piso_tx_nbit, MSB-first and LSB-first
// instances driven by shared stimulus.
module tb_piso_tx_nbit;

    logic       clock;
    logic       R_n;
    logic [7:0] D;
    logic       start;
    logic       E;
    logic       ready_m, q_m, valid_m, done_m;
    logic       ready_l, q_l, valid_l, done_l;

    int total = 0;
    int bad   = 0;

    logic [7:0] exp_msb;
    logic [7:0] exp_lsb;
    logic [9:0] exp_st;

    piso_tx_nbit #(.N(8), .MSB_FIRST(1'b1)) dut_m (
        .clock(clock), .R_n(R_n), .D(D), .start(start), .E(E),
        .ready(ready_m), .Q(q_m), .valid(valid_m), .done(done_m)
    );

    piso_tx_nbit #(.N(8), .MSB_FIRST(1'b0)) dut_l (
        .clock(clock), .R_n(R_n), .D(D), .start(start), .E(E),
        .ready(ready_l), .Q(q_l), .valid(valid_l), .done(done_l)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    task automatic chk(input string tag, input logic obs, input logic exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%b expected=%b", tag, obs, exp);
        end
    endtask

    initial begin
        R_n   = 1'b0;
        start = 1'b0;
        E     = 1'b1;
        D     = 8'h00;
        repeat (2) @(negedge clock);
        chk("rst_ready", ready_m, 1'b1);
        chk("rst_q", q_m, 1'b0);
        chk("rst_valid", valid_m, 1'b0);
        chk("rst_done", done_m, 1'b0);

        // MSB-first and LSB-first, D=C1; start right after reset release
        R_n     = 1'b1;
        D       = 8'hC1;
        start   = 1'b1;
        exp_msb = 8'b1100_0001;
        exp_lsb = 8'b1000_0011;
        @(negedge clock);
        start = 1'b0;
        D     = 8'h00;
        for (int k = 0; k < 8; k++) begin
            chk("c1_msb_q", q_m, exp_msb[7-k]);
            chk("c1_lsb_q", q_l, exp_lsb[7-k]);
            chk("c1_valid", valid_m, 1'b1);
            chk("c1_ready", ready_m, 1'b0);
            chk("c1_done", done_m, 1'b0);
            @(negedge clock);
        end
`ifdef PIPO_PARITY_EN
        chk("c1_par_q", q_m, 1'b1);
        chk("c1_par_ql", q_l, 1'b1);
        chk("c1_par_valid", valid_m, 1'b1);
        chk("c1_par_done", done_m, 1'b0);
        @(negedge clock);
`endif
        chk("c1_done_m", done_m, 1'b1);
        chk("c1_done_l", done_l, 1'b1);
        chk("c1_done_ready", ready_m, 1'b1);
        chk("c1_done_valid", valid_m, 1'b0);
        chk("c1_done_q", q_m, 1'b0);
        @(negedge clock);
        chk("c1_done_pulse", done_m, 1'b0);
        chk("c1_idle_ready", ready_m, 1'b1);

        // Stall: D=A5, E low in cycles 3 and 4
        D      = 8'hA5;
        start  = 1'b1;
        exp_st = 10'b10_1110_0101;
        @(negedge clock);
        start = 1'b0;
        for (int c = 1; c <= 10; c++) begin
            chk("st_q", q_m, exp_st[10-c]);
            chk("st_valid", valid_m, 1'b1);
            chk("st_ready", ready_m, 1'b0);
            chk("st_done", done_m, 1'b0);
            E = (c == 3 || c == 4) ? 1'b0 : 1'b1;
            @(negedge clock);
        end
`ifdef PIPO_PARITY_EN
        chk("st_par_q", q_m, 1'b0);
        chk("st_par_valid", valid_m, 1'b1);
        @(negedge clock);
`endif
        chk("st_done_m", done_m, 1'b1);
        chk("st_done_l", done_l, 1'b1);
        @(negedge clock);

        // Busy start ignored, then back-to-back start in the done cycle
        D       = 8'h3C;
        start   = 1'b1;
        exp_msb = 8'b0011_1100;
        @(negedge clock);
        for (int c = 1; c <= 8; c++) begin
            chk("bz_q", q_m, exp_msb[8-c]);
            chk("bz_ql", q_l, exp_msb[8-c]);
            chk("bz_ready", ready_m, 1'b0);
            start = (c == 3) ? 1'b1 : 1'b0;
            D     = (c == 3) ? 8'hFF : 8'h3C;
            @(negedge clock);
        end
`ifdef PIPO_PARITY_EN
        chk("bz_par_q", q_m, 1'b0);
        @(negedge clock);
`endif
        chk("bz_done", done_m, 1'b1);
        chk("bz_done_ready", ready_m, 1'b1);
        D       = 8'h0F;
        start   = 1'b1;
        exp_msb = 8'b0000_1111;
        exp_lsb = 8'b1111_0000;
        @(negedge clock);
        start = 1'b0;
        D     = 8'h00;
        chk("b2b_ready", ready_m, 1'b0);
        chk("b2b_valid", valid_m, 1'b1);
        chk("b2b_done", done_m, 1'b0);
        for (int k = 0; k < 8; k++) begin
            chk("b2b_q", q_m, exp_msb[7-k]);
            chk("b2b_ql", q_l, exp_lsb[7-k]);
            chk("b2b_busy", ready_m, 1'b0);
            @(negedge clock);
        end
`ifdef PIPO_PARITY_EN
        chk("b2b_par_q", q_m, 1'b0);
        @(negedge clock);
`endif
        chk("b2b_done_m", done_m, 1'b1);
        @(negedge clock);

        // Reset mid-transfer in cycle 4
        D     = 8'hC1;
        start = 1'b1;
        @(negedge clock);
        start = 1'b0;
        repeat (3) @(negedge clock);
        chk("mr_pre_valid", valid_m, 1'b1);
        R_n = 1'b0;
        #1;
        chk("mr_q", q_m, 1'b0);
        chk("mr_valid", valid_m, 1'b0);
        chk("mr_ready", ready_m, 1'b1);
        chk("mr_done", done_m, 1'b0);
        chk("mr_ready_l", ready_l, 1'b1);
        @(negedge clock);
        R_n = 1'b1;
        for (int c = 0; c < 12; c++) begin
            @(negedge clock);
            chk("mr_no_done", done_m, 1'b0);
            chk("mr_no_done_l", done_l, 1'b0);
            chk("mr_idle_valid", valid_m, 1'b0);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
